// File: rtl/game_pkg.sv
// Shared types and default constants for the cannon-game round sequencer.
package game_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SHOTS_W = 4;

    localparam int unsigned SHOTS_PER_GAME_DEF = 8;
    localparam int unsigned SHOW_CYCLES_DEF    = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        StIdle,
        StNewTgt,
        StArmed,
        StWait,
        StShow,
        StOver
    } round_state_t;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Control/status bundle between the controls block, the round sequencer and the datapath.
interface game_round_ctrl_if;
    import game_pkg::*;

    logic               ena;
    logic               start_new_game;
    logic               shoot_req;
    logic               result_valid;
    logic               hit;
    logic               shoot;
    logic               new_target;
    logic [SCORE_W-1:0] score;
    logic [SHOTS_W-1:0] shots_left;
    logic               busy;
    logic               game_over;
    logic               timeout_flag;

    modport master (
        output ena, start_new_game, shoot_req, result_valid, hit,
        input  shoot, new_target, score, shots_left, busy, game_over, timeout_flag
    );

    modport slave (
        input  ena, start_new_game, shoot_req, result_valid, hit,
        output shoot, new_target, score, shots_left, busy, game_over, timeout_flag
    );

endinterface

// File: rtl/game_round_ctrl_rise_detect.sv
// Registered rising-edge detector for a level input; a level already high when reset is
// released is not reported as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;
    logic primed_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            level_q  <= level_i;
            primed_q <= 1'b1;
        end
    end

    // primed_q masks the first post-reset cycle, before level_q holds a real sample
    assign rise_o = primed_q & level_i & ~level_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: gates shots, requests targets, keeps score and shot budget.
// Optional result timeout in WAIT is enabled by defining GAME_ROUND_TIMEOUT_EN.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SHOTS_PER_GAME = SHOTS_PER_GAME_DEF,
    parameter int unsigned SHOW_CYCLES    = SHOW_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic              clk,
    input logic              rst_n,
    game_round_ctrl_if.slave bus
);

    localparam logic [SHOTS_W-1:0] ShotsLoad = SHOTS_W'(SHOTS_PER_GAME);
    localparam logic [7:0]         ShowLoad  = 8'(SHOW_CYCLES);

    round_state_t       state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SHOTS_W-1:0] shots_q, shots_d;
    logic [7:0]         show_cnt_q, show_cnt_d;
    logic               last_hit_q, last_hit_d;
    logic               shoot_q, shoot_d;
    logic               new_target_q, new_target_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;
    logic               start_rise;

`ifdef GAME_ROUND_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       tflag_q, tflag_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    rise_detect u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (bus.start_new_game),
        .rise_o  (start_rise)
    );

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        shots_d    = shots_q;
        show_cnt_d = show_cnt_q;
        last_hit_d = last_hit_q;
        shoot_d    = 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        tflag_d    = tflag_q;
`endif
        if (start_rise) begin
            state_d    = StNewTgt;
            score_d    = '0;
            shots_d    = ShotsLoad;
            last_hit_d = 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
            tflag_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                end
                StNewTgt: state_d = StArmed;
                StArmed: begin
                    if (bus.shoot_req) begin
                        state_d = StWait;
                        shoot_d = 1'b1;
`ifdef GAME_ROUND_TIMEOUT_EN
                        tflag_d    = 1'b0;
                        wait_cnt_d = '0;
`endif
                    end
                end
                StWait: begin
                    if (bus.result_valid) begin
                        shots_d    = shots_q - 1'b1;
                        last_hit_d = bus.hit;
                        if (bus.hit && (score_q != {SCORE_W{1'b1}})) begin
                            score_d = score_q + 1'b1;
                        end
                        show_cnt_d = ShowLoad;
                        state_d    = StShow;
                    end
`ifdef GAME_ROUND_TIMEOUT_EN
                    else if (wait_cnt_q == WaitLast) begin
                        // no result in time: score the shot as a miss
                        shots_d    = shots_q - 1'b1;
                        last_hit_d = 1'b0;
                        tflag_d    = 1'b1;
                        show_cnt_d = ShowLoad;
                        state_d    = StShow;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`endif
                end
                StShow: begin
                    show_cnt_d = show_cnt_q - 1'b1;
                    if (show_cnt_q == 8'd1) begin
                        if (shots_q == '0) begin
                            state_d = StOver;
                        end else if (last_hit_q) begin
                            state_d = StNewTgt;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                StOver: begin
                end
                default: state_d = StIdle;
            endcase
        end

        new_target_d = (state_d == StNewTgt);
        busy_d       = (state_d == StNewTgt) || (state_d == StWait) || (state_d == StShow);
        game_over_d  = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            score_q      <= '0;
            shots_q      <= '0;
            show_cnt_q   <= '0;
            last_hit_q   <= 1'b0;
            shoot_q      <= 1'b0;
            new_target_q <= 1'b0;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
            wait_cnt_q   <= '0;
            tflag_q      <= 1'b0;
`endif
        end else if (bus.ena) begin
            state_q      <= state_d;
            score_q      <= score_d;
            shots_q      <= shots_d;
            show_cnt_q   <= show_cnt_d;
            last_hit_q   <= last_hit_d;
            shoot_q      <= shoot_d;
            new_target_q <= new_target_d;
            busy_q       <= busy_d;
            game_over_q  <= game_over_d;
`ifdef GAME_ROUND_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            tflag_q      <= tflag_d;
`endif
        end else begin
            shoot_q      <= 1'b0;
            new_target_q <= 1'b0;
        end
    end

    assign bus.shoot      = shoot_q;
    assign bus.new_target = new_target_q;
    assign bus.score      = score_q;
    assign bus.shots_left = shots_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = game_over_q;
`ifdef GAME_ROUND_TIMEOUT_EN
    assign bus.timeout_flag = tflag_q;
`else
    assign bus.timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomised games against a rule-level model; expected output events are queued by the
// driver and consumed by an independent monitor.
module tb_game_round_ctrl;
    import game_pkg::*;

    localparam int SPG = 8;
    localparam int SC  = 16;
    localparam int TO  = 64;

    localparam int EvNewTgt = 1;
    localparam int EvShoot  = 2;
    localparam int EvResult = 3;
    localparam int EvOver   = 4;

    typedef struct {
        int kind;
        int cyc;
        int score;
        int shots;
        bit busy;
        bit over;
        bit tflag;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    game_round_ctrl_if bus();

    game_round_ctrl #(
        .SHOTS_PER_GAME (SPG),
        .SHOW_CYCLES    (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ev_t q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_quiet = 1'b1;
    int  m_score = 0;
    int  m_shots = 0;
    bit  m_tflag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    function automatic void expect_ev(input int kind, input int at, input bit busy,
                                      input bit over);
        ev_t e;
        e.kind  = kind;
        e.cyc   = at;
        e.score = m_score;
        e.shots = m_shots;
        e.busy  = busy;
        e.over  = over;
        e.tflag = m_tflag;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_shoot"}, int'(bus.shoot), 0);
        check({tag, "_new_target"}, int'(bus.new_target), 0);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_shots_left"}, int'(bus.shots_left), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_game_over"}, int'(bus.game_over), 0);
        check({tag, "_timeout_flag"}, int'(bus.timeout_flag), 0);
    endtask

    // Monitor: classify each cycle's outputs into an event and compare with the queue head.
    initial begin : monitor
        ev_t e;
        int  kind;
        int  p_score = 0;
        int  p_shots = 0;
        bit  p_over = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_quiet) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_event: kind %0d due at cycle %0d, not observed by cycle %0d",
                             q[0].kind, q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                kind = 0;
                if (bus.new_target) kind = EvNewTgt;
                else if (bus.shoot) kind = EvShoot;
                else if (int'(bus.score) != p_score || int'(bus.shots_left) != p_shots)
                    kind = EvResult;
                else if (bus.game_over && !p_over) kind = EvOver;
                if (kind != 0) begin
                    vectors++;
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected",
                                 kind, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.kind != kind || e.cyc != cyc || e.score != int'(bus.score) ||
                            e.shots != int'(bus.shots_left) || e.busy != bus.busy ||
                            e.over != bus.game_over || e.tflag != bus.timeout_flag) begin
                            miscompares++;
                            $display({"FAIL event: got kind %0d cyc %0d score %0d shots %0d ",
                                      "busy %0d over %0d tflag %0d, want kind %0d cyc %0d ",
                                      "score %0d shots %0d busy %0d over %0d tflag %0d"},
                                     kind, cyc, bus.score, bus.shots_left, bus.busy,
                                     bus.game_over, bus.timeout_flag, e.kind, e.cyc, e.score,
                                     e.shots, e.busy, e.over, e.tflag);
                        end
                    end
                end
            end
            p_score = int'(bus.score);
            p_shots = int'(bus.shots_left);
            p_over  = bus.game_over;
        end
    end

    task automatic start_game(output int armed_at);
        bus.start_new_game = 1'b1;
        m_score = 0;
        m_shots = SPG;
        m_tflag = 1'b0;
        expect_ev(EvNewTgt, cyc + 1, 1'b1, 1'b0);
        armed_at = cyc + 2;
        tick();
        bus.start_new_game = 1'b0;
    endtask

    task automatic play_game();
        int armed_at, n, m, d, entry, freeze, show_exit, restarts;
        bit hit, timed_out;
        restarts = 0;
        start_game(armed_at);
        forever begin
            while (cyc < armed_at) tick();
            // results arriving while ARMED must be ignored
            repeat ($urandom_range(0, 3)) begin
                bus.result_valid = ($urandom_range(0, 2) == 0);
                bus.hit = 1'b1;
                tick();
            end
            bus.result_valid = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                bus.ena = 1'b0;
                bus.shoot_req = 1'b1;
                tick();
                bus.shoot_req = 1'b0;
                tick_n(int'($urandom_range(0, 2)));
                bus.ena = 1'b1;
            end

            n = cyc;
            bus.shoot_req = 1'b1;
            m_tflag = 1'b0;
            expect_ev(EvShoot, n + 1, 1'b1, 1'b0);
            tick();
            bus.shoot_req = 1'b0;

`ifdef GAME_ROUND_TIMEOUT_EN
            d = ($urandom_range(0, 5) == 0) ? TO + 5 : int'($urandom_range(1, 6));
            timed_out = (d > TO);
`else
            d = int'($urandom_range(1, 6));
            timed_out = 1'b0;
`endif
            m = n + d;
            while (cyc < (timed_out ? n + TO : m)) begin
                bus.shoot_req = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.shoot_req = 1'b0;

            if (!timed_out && restarts < 3 && $urandom_range(0, 9) == 0) begin
                // start edge coincides with the result: the result is dropped
                restarts++;
                bus.result_valid = 1'b1;
                bus.hit = ($urandom_range(0, 1) == 1);
                start_game(armed_at);
                bus.result_valid = 1'b0;
                continue;
            end

            if (timed_out) begin
                hit = 1'b0;
                m_tflag = 1'b1;
            end else begin
                hit = ($urandom_range(0, 1) == 1);
                bus.result_valid = 1'b1;
                bus.hit = hit;
                if (hit && m_score < 15) m_score++;
            end
            m_shots--;
            entry = cyc + 1;
            freeze = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            show_exit = entry + SC + freeze;
            expect_ev(EvResult, entry, 1'b1, 1'b0);
            if (m_shots == 0) expect_ev(EvOver, show_exit, 1'b0, 1'b1);
            else if (hit) expect_ev(EvNewTgt, show_exit, 1'b1, 1'b0);
            armed_at = hit ? show_exit + 1 : show_exit;
            tick();
            bus.result_valid = 1'b0;
            bus.hit = 1'b0;

            if (freeze > 0) begin
                bus.ena = 1'b0;
                tick_n(freeze);
                bus.ena = 1'b1;
            end
            while (cyc < show_exit) begin
                bus.result_valid = ($urandom_range(0, 3) == 0);
                bus.hit = ($urandom_range(0, 1) == 1);
                bus.shoot_req = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.result_valid = 1'b0;
            bus.hit = 1'b0;
            bus.shoot_req = 1'b0;
            if (m_shots == 0) break;
        end
        tick_n(2);
        bus.shoot_req = 1'b1;
        tick();
        bus.shoot_req = 1'b0;
        tick_n(2);
    endtask

    initial begin : driver
        int armed_at;
        bus.ena = 1'b1;
        bus.start_new_game = 1'b1;
        bus.shoot_req = 1'b0;
        bus.result_valid = 1'b0;
        bus.hit = 1'b0;
        rst_n = 1'b0;
        tick_n(3);
        rst_n = 1'b1;
        tick();
        mon_quiet = 1'b0;
        tick_n(4);
        check_idle_outputs("reset");
        bus.start_new_game = 1'b0;
        tick();

        repeat (5) play_game();

        // reset in WAIT discards the pending result
        start_game(armed_at);
        while (cyc < armed_at) tick();
        bus.shoot_req = 1'b1;
        expect_ev(EvShoot, cyc + 1, 1'b1, 1'b0);
        tick();
        bus.shoot_req = 1'b0;
        tick_n(2);
        mon_quiet = 1'b1;
        rst_n = 1'b0;
        bus.result_valid = 1'b1;
        bus.hit = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.result_valid = 1'b0;
        bus.hit = 1'b0;
        check_idle_outputs("midreset");
        tick();
        mon_quiet = 1'b0;
        bus.result_valid = 1'b1;
        bus.shoot_req = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        bus.shoot_req = 1'b0;
        tick_n(5);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the cannon game. It sits between the input controls block and the trajectory/target datapath. It gates player shots so only one trajectory calculation is in flight, and requests a new target after a hit. It also counts shots and score, and declares game over when the shot budget is spent. Its outputs feed the trajectory calculator (`shoot`), the target generator (`new_target`) and the top-level status pins.

## Interface
Parameters:
- `SHOTS_PER_GAME`, 8: shots per game; legal range 1..15.
- `SHOW_CYCLES`, 16: hold time after each result before the next shot is armed; legal range 1..255.
- `TIMEOUT_CYCLES`, 64: cycles allowed for a result in WAIT; used only with the macro; legal range 1..255.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `ena`, in, 1: when 0, state, counters and outputs hold, and all pulses are suppressed.
- `start_new_game`, in, 1: level input; only its rising edge is used.
- `shoot_req`, in, 1: one-cycle pulse from the controls block.
- `result_valid`, in, 1: one-cycle pulse from the trajectory calculator.
- `hit`, in, 1: qualified by `result_valid`.
- `shoot`, out, 1: one-cycle fire pulse to the trajectory calculator.
- `new_target`, out, 1: one-cycle pulse to the target generator.
- `score`, out, 4: hits this game; saturates at 15.
- `shots_left`, out, 4: remaining shots.
- `busy`, out, 1: high in NEWTGT, WAIT or SHOW.
- `game_over`, out, 1: high in OVER.
- `timeout_flag`, out, 1: sticky result-timeout indicator; tied to 0 without the macro.

## Operation
- States: IDLE, NEWTGT, ARMED, WAIT, SHOW, OVER.
- Reset values: state IDLE; all outputs 0; internal counters 0.
- IDLE: waits for a `start_new_game` rising edge, then goes to NEWTGT.
- Start edge in any state:
  - loads `score` = 0 and `shots_left` = `SHOTS_PER_GAME`;
  - clears `timeout_flag` and the last-hit bit;
  - goes to NEWTGT.
  - It has priority over every other event in the same cycle.
- NEWTGT: lasts one cycle; `new_target` = 1; then goes to ARMED.
- ARMED: on `shoot_req`, goes to WAIT and clears `timeout_flag`. `shoot_req` is ignored in every other state; there is no queuing.
- WAIT: on `result_valid`:
  - decrement `shots_left`;
  - if `hit`, increment `score` (saturating) and set the last-hit bit;
  - if not `hit`, clear the last-hit bit;
  - load the show counter with `SHOW_CYCLES` and go to SHOW.
- `result_valid` outside WAIT is ignored.
- SHOW: the counter decrements each cycle. When it reaches 0:
  - if `shots_left` = 0, go to OVER;
  - else if last-hit, go to NEWTGT;
  - else go to ARMED.
- OVER: holds `score` until the next start edge.
- Edge detector: registered copy of `start_new_game`, reset to 0. A level already high at reset release does not start a game.

## Timing
- `shoot_req` sampled in ARMED at cycle N:
  - `shoot` is high for cycle N+1 only;
  - state is WAIT from N+1.
- `result_valid` at cycle M in WAIT:
  - `score` and `shots_left` are updated at M+1;
  - SHOW is entered at M+1 and exited at M+1+`SHOW_CYCLES`.
- Start edge at cycle K: NEWTGT (with `new_target` high) during K+1; ARMED at K+2.
- All outputs are registered; there are no combinational input-to-output paths.
- `ena` low mid-operation freezes the FSM in place. A pulse arriving while `ena` = 0 is lost.
- `rst_n` low mid-operation returns the block to IDLE on the next edge. Any pending result is discarded.

## Configuration
- Macro: `GAME_ROUND_TIMEOUT_EN`.
- Defined:
  - a WAIT-cycle counter is present;
  - after `TIMEOUT_CYCLES` cycles in WAIT without `result_valid`, the shot is scored as a miss;
  - `shots_left` is decremented, SHOW is entered and `timeout_flag` = 1.
- Undefined:
  - the counter is absent and WAIT waits indefinitely;
  - `timeout_flag` is constant 0.

## Structure
- Shared package `game_pkg`:
  - state enum `round_state_t`;
  - `SCORE_W` = 4 and `SHOTS_W` = 4;
  - default constants for the three parameters.
- One sub-module, `rise_detect`: registered rising-edge detector for `start_new_game`, reusable for other level inputs.
- Show counter and timeout counter are local to `game_round_ctrl`.

## Test plan
- Reset, then a start edge: `new_target` pulses once, then ARMED with `shots_left` = 8 and `score` = 0.
- `shoot_req` at N → `shoot` high at N+1 only. A second `shoot_req` at N+3 produces no `shoot`.
- Miss (`result_valid` = 1, `hit` = 0): `shots_left` 8→7, `score` 0, no `new_target`, ARMED after 16 SHOW cycles.
- Hit: `score` 0→1, then `new_target` pulses on SHOW exit. After 8 total results, `game_over` = 1 and `busy` = 0.
- Start edge in the same cycle as `result_valid` in WAIT: `score` = 0 and `shots_left` = 8; the result is ignored.
- Macro defined with `TIMEOUT_CYCLES` = 64: no result after `shoot` → after 64 WAIT cycles, `timeout_flag` = 1 and `shots_left` decrements; the next `shoot` clears the flag.
